// File: rtl/fetch_q.sv
// Instruction fetch queue: issues ROM reads while the queue has room and
// presents the head entry to the decoder; redirects flush and refetch.
module fetch_q #(
  parameter int D      = 12,
  parameter int DEPTH  = 4,
  parameter int END_PC = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  output logic         rom_rd,
  output logic [D-1:0] rom_addr,
  input  logic [8:0]   rom_data,
  output logic [8:0]   instr,
  output logic [D-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [D-1:0] redirect_target,
  output logic         done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [D-1:0]  L_END   = D'(END_PC);
  localparam logic [CW:0]   L_DEPTH = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] L_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [D-1:0]    r_fetch_pc;
  logic [CW-1:0]   r_count;
  logic            r_inflight;
  logic [D-1:0]    r_infl_pc;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [8:0]      r_q_data [DEPTH];
  logic [D-1:0]    r_q_pc   [DEPTH];

  logic            w_run, w_redir, w_issue, w_push, w_pop, w_at_end, w_end_cond;
  logic [CW:0]     w_occ;

  assign w_run      = (r_state == S_RUN);
  assign w_redir    = w_run && redirect;
  // Room is judged on entries held plus the one response still in flight
  assign w_occ      = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_at_end   = (r_fetch_pc == L_END);
  assign w_issue    = w_run && !redirect && (w_occ < L_DEPTH) && !w_at_end;
  assign w_push     = w_run && !redirect && r_inflight;
  assign w_pop      = w_run && !redirect && (r_count != '0) && instr_ready;
  assign w_end_cond = w_at_end && (r_count == '0) && !r_inflight;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = S_RUN;
      S_RUN:   if (redirect) w_next = S_FLUSH;
               else if (w_end_cond) w_next = S_DONE;
      S_FLUSH: w_next = S_RUN;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rom_rd      = w_issue;
    rom_addr    = w_issue ? r_fetch_pc : '0;
    instr_valid = w_run && (r_count != '0);
    instr       = '0;
    instr_pc    = '0;
    if (instr_valid) begin
      instr    = r_q_data[r_rd_ptr];
      instr_pc = r_q_pc[r_rd_ptr];
    end
    done        = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_infl_pc  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_infl_pc <= r_fetch_pc;

      if (r_state == S_IDLE && req) r_fetch_pc <= '0;
      else if (w_redir)             r_fetch_pc <= redirect_target;
      else if (w_issue)             r_fetch_pc <= r_fetch_pc + D'(1);

      if (w_redir) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_q_data[r_wr_ptr] <= rom_data;
      r_q_pc[r_wr_ptr]   <= r_infl_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(w_push && r_count == L_FULL))
      else $error("fetch_q: push into full queue");
  end

endmodule

// File: tb/tb_fetch_q.sv
// Directed bench for fetch_q: straight run, backpressure, redirects,
// redirect racing the completion condition, and mid-run reset.
module tb_fetch_q;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        rom_rd;
  logic [11:0] rom_addr;
  logic [8:0]  rom_data = '0;
  logic [8:0]  instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_target = '0;
  logic        done;

  logic [8:0]  rom_xor = '0;
  int          n_assert = 0;
  int          n_fail = 0;

  fetch_q #(.D(12), .DEPTH(4), .END_PC(128)) dut (
    .clk(clk), .reset(reset), .req(req),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .done(done)
  );

  always #5 clk = ~clk;

  // ROM responder: data one cycle after the strobe, junk otherwise
  always @(posedge clk) rom_data <= rom_rd ? (rom_addr[8:0] ^ rom_xor) : 9'h1FF;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic start();
    req = 1'b1;
    cyc();
    req = 1'b0;
    #1;
  endtask

  logic [31:0] exp_pc;
  int          bad_addr, npulse;
  logic        found;

  initial begin
    // reset values
    do_reset();
    #1;
    chk("rst_rom_rd", 32'(rom_rd), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_instr_pc", 32'(instr_pc), 0);
    chk("rst_done", 32'(done), 0);

    // straight run
    rom_xor = 9'h000;
    instr_ready = 1'b1;
    start();
    chk("sr_first_rd", 32'(rom_rd), 1);
    chk("sr_first_addr", 32'(rom_addr), 0);
    chk("sr_valid_t0", 32'(instr_valid), 0);
    cyc();
    chk("sr_second_addr", 32'(rom_addr), 1);
    chk("sr_valid_t1", 32'(instr_valid), 0);
    cyc();
    chk("sr_valid_t2", 32'(instr_valid), 1);
    chk("sr_pc_t2", 32'(instr_pc), 0);
    exp_pc = 0; bad_addr = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (rom_rd && rom_addr >= 12'd128) bad_addr++;
      if (instr_valid) begin
        chk("sr_pc", 32'(instr_pc), exp_pc);
        chk("sr_instr", 32'(instr), 32'(exp_pc[8:0] ^ rom_xor));
        exp_pc++;
      end
      cyc();
    end
    chk("sr_done", 32'(done), 1);
    chk("sr_delivered", exp_pc, 128);
    chk("sr_addr_range", 32'(bad_addr), 0);
    chk("sr_done_no_rd", 32'(rom_rd), 0);
    redirect = 1'b1; redirect_target = 12'd5; req = 1'b1;
    cyc();
    redirect = 1'b0; req = 1'b0;
    #1;
    chk("done_sticky", 32'(done), 1);
    chk("done_ignore_redir_rd", 32'(rom_rd), 0);
    chk("done_valid", 32'(instr_valid), 0);

    // backpressure, then simultaneous push/pop at count 3
    do_reset();
    rom_xor = 9'h155;
    instr_ready = 1'b0;
    start();
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      if (rom_rd) begin
        chk("bp_addr", 32'(rom_addr), 32'(npulse));
        npulse++;
      end
      cyc();
    end
    chk("bp_pulses", 32'(npulse), 4);
    chk("bp_valid", 32'(instr_valid), 1);
    chk("bp_head_pc", 32'(instr_pc), 0);
    chk("bp_head_instr", 32'(instr), 32'(9'h000 ^ 9'h155));
    instr_ready = 1'b1;
    #1;
    chk("bp_noissue_full", 32'(rom_rd), 0);
    cyc();
    instr_ready = 1'b0;
    #1;
    chk("bp_issue_after_pop", 32'(rom_rd), 1);
    chk("bp_issue_addr", 32'(rom_addr), 4);
    chk("bp_head_pc1", 32'(instr_pc), 1);
    cyc();
    instr_ready = 1'b1;
    #1;
    chk("pp_noissue", 32'(rom_rd), 0);
    chk("pp_head_pc1", 32'(instr_pc), 1);
    cyc();
    instr_ready = 1'b0;
    #1;
    chk("pp_head_pc2", 32'(instr_pc), 2);
    chk("pp_count3_rd", 32'(rom_rd), 1);
    chk("pp_count3_addr", 32'(rom_addr), 5);
    instr_ready = 1'b1;
    #1;
    exp_pc = 2;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid) begin
        chk("pp_order_pc", 32'(instr_pc), exp_pc);
        chk("pp_order_instr", 32'(instr), 32'(exp_pc[8:0] ^ rom_xor));
        exp_pc++;
      end
      cyc();
    end
    chk("pp_drained", exp_pc, 14);

    // redirect at head PC 5, redirect during FLUSH ignored
    do_reset();
    instr_ready = 1'b1;
    start();
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (instr_valid && instr_pc == 12'd5) found = 1'b1;
      else cyc();
    end
    chk("rd_reach_pc5", 32'(found), 1);
    redirect = 1'b1; redirect_target = 12'd40;
    #1;
    chk("rd_kill_issue", 32'(rom_rd), 0);
    cyc();
    redirect_target = 12'd99;
    #1;
    chk("rd_flush_valid", 32'(instr_valid), 0);
    chk("rd_flush_rd", 32'(rom_rd), 0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("rd_target_rd", 32'(rom_rd), 1);
    chk("rd_target_addr", 32'(rom_addr), 40);
    cyc();
    chk("rd_valid_gap", 32'(instr_valid), 0);
    cyc();
    chk("rd_valid", 32'(instr_valid), 1);
    chk("rd_pc40", 32'(instr_pc), 40);
    chk("rd_instr40", 32'(instr), 32'(9'd40 ^ 9'h155));
    cyc();
    chk("rd_pc41", 32'(instr_pc), 41);

    // redirect with a response in flight
    do_reset();
    instr_ready = 1'b1;
    start();
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (rom_rd && rom_addr == 12'd7) found = 1'b1;
      else cyc();
    end
    chk("if_reach_addr7", 32'(found), 1);
    cyc();
    redirect = 1'b1; redirect_target = 12'd20;
    #1;
    chk("if_kill_issue", 32'(rom_rd), 0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("if_flush_valid", 32'(instr_valid), 0);
    cyc();
    chk("if_target_rd", 32'(rom_rd), 1);
    chk("if_target_addr", 32'(rom_addr), 20);
    chk("if_dropped", 32'(instr_valid), 0);
    cyc();
    chk("if_gap", 32'(instr_valid), 0);
    cyc();
    chk("if_valid20", 32'(instr_valid), 1);
    chk("if_pc20", 32'(instr_pc), 20);

    // redirect on the cycle the completion condition holds
    do_reset();
    rom_xor = 9'h000;
    instr_ready = 1'b1;
    start();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (instr_valid && instr_pc == 12'd127) found = 1'b1;
      else cyc();
    end
    chk("rc_reach_pc127", 32'(found), 1);
    cyc();
    chk("rc_empty", 32'(instr_valid), 0);
    chk("rc_no_rd", 32'(rom_rd), 0);
    chk("rc_not_done_yet", 32'(done), 0);
    redirect = 1'b1; redirect_target = 12'd100;
    cyc();
    redirect = 1'b0;
    #1;
    chk("rc_redirect_wins", 32'(done), 0);
    chk("rc_flush_valid", 32'(instr_valid), 0);
    cyc();
    chk("rc_target_addr", 32'(rom_addr), 100);
    exp_pc = 100;
    for (int k = 0; k < 100 && !done; k++) begin
      if (instr_valid) begin
        chk("rc_pc", 32'(instr_pc), exp_pc);
        exp_pc++;
      end
      cyc();
    end
    chk("rc_done", 32'(done), 1);
    chk("rc_delivered", exp_pc, 128);

    // reset mid-run, then restart
    do_reset();
    instr_ready = 1'b1;
    start();
    for (int k = 0; k < 10; k++) cyc();
    reset = 1'b1;
    cyc();
    chk("mr_rom_rd", 32'(rom_rd), 0);
    chk("mr_rom_addr", 32'(rom_addr), 0);
    chk("mr_valid", 32'(instr_valid), 0);
    chk("mr_instr", 32'(instr), 0);
    chk("mr_instr_pc", 32'(instr_pc), 0);
    chk("mr_done", 32'(done), 0);
    reset = 1'b0;
    cyc();
    chk("mr_idle_valid", 32'(instr_valid), 0);
    chk("mr_idle_rd", 32'(rom_rd), 0);
    start();
    chk("mr_restart_rd", 32'(rom_rd), 1);
    chk("mr_restart_addr", 32'(rom_addr), 0);
    cyc();
    cyc();
    chk("mr_restart_valid", 32'(instr_valid), 1);
    chk("mr_restart_pc", 32'(instr_pc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_q.md
FETCH_Q -- requirements
Module: fetch_q

Interface
REQ-001 Parameter D, default 12: program counter width.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; must be a power of two, 2 or more.
REQ-003 Parameter END_PC, default 128: fetch address at which the run completes.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req, input, 1: start request, sampled only in IDLE.
REQ-007 Port rom_rd, output, 1: instruction ROM read strobe.
REQ-008 Port rom_addr, output, D: ROM read address.
REQ-009 Port rom_data, input, 9: machine code, valid the cycle after rom_rd.
REQ-010 Port instr, output, 9: head-of-queue machine code.
REQ-011 Port instr_pc, output, D: PC of the head entry.
REQ-012 Port instr_valid, output, 1: head entry valid.
REQ-013 Port instr_ready, input, 1: decoder accepts the head entry.
REQ-014 Port redirect, input, 1: jump/branch taken; flush the queue.
REQ-015 Port redirect_target, input, D: new fetch PC.
REQ-016 Port done, output, 1: run complete.

Function
REQ-017 FSM states SHALL be IDLE, RUN, FLUSH and DONE.
REQ-018 In IDLE, req=1 SHALL load fetch_pc=0 and enter RUN next cycle.
REQ-019 In RUN, rom_rd=1 with rom_addr=fetch_pc SHALL assert when count+inflight<DEPTH and fetch_pc!=END_PC; fetch_pc then increments.
REQ-020 fetch_pc SHALL wrap modulo 2^D.
REQ-021 inflight (0 or 1) SHALL set on an issue; the next cycle rom_data is pushed with its PC unless the response is killed.
REQ-022 Pop SHALL occur when instr_valid && instr_ready; push and pop SHALL be allowed in the same cycle, count unchanged.
REQ-023 The issue rule SHALL make overflow impossible; a push when full is a design error, covered by an assertion.
REQ-024 instr_valid SHALL equal (count!=0) and SHALL NOT assert outside RUN.
REQ-025 Head-to-output latency: instr/instr_pc SHALL be driven combinationally from the head entry. ROM-issue-to-instr_valid latency on an empty queue SHALL be 2 cycles.
REQ-026 redirect in RUN SHALL take priority over push, pop and issue: clear the queue (count=0), kill any inflight response, load fetch_pc=redirect_target, and enter FLUSH.
REQ-027 FLUSH SHALL last one cycle with no issue, no push and instr_valid=0, then return to RUN.
REQ-028 redirect SHALL be ignored in IDLE, FLUSH and DONE.
REQ-029 In RUN, when fetch_pc==END_PC, count==0 and inflight==0, the FSM SHALL enter DONE.
REQ-030 In DONE, done=1 and rom_rd=0; DONE SHALL exit only by reset.
REQ-031 A redirect to a target below END_PC in the cycle the DONE condition is met SHALL win; the FSM goes to FLUSH, not DONE.
REQ-032 req SHALL be ignored outside IDLE.

Reset
REQ-033 reset=1 SHALL, on the next edge and from any state including mid-run, force state=IDLE, fetch_pc=0, count=0, inflight=0 and queue pointers=0.
REQ-034 During and after reset: rom_rd=0, rom_addr=0, instr_valid=0, instr=0, instr_pc=0, done=0.
REQ-035 A response arriving after reset SHALL be discarded.

Verification
REQ-036 Straight run: reset, req pulse, ROM[i]=i, instr_ready=1 -> instr_pc 0..127 in order, each instr=ROM value, then done=1; no rom_rd with addr>=128.
REQ-037 Backpressure: instr_ready=0 after start -> exactly 4 rom_rd pulses (addr 0..3); instr_valid held with instr_pc=0; no further issue until the first pop.
REQ-038 Redirect: at instr_pc=5 pulse redirect with target=40 -> one FLUSH cycle with instr_valid=0; next valid instr_pc=40; no entry with PC 6..9 is delivered.
REQ-039 Redirect with inflight: redirect in the cycle after rom_rd addr=7 -> the addr-7 response is dropped; next issue addr=target.
REQ-040 Simultaneous push/pop with count=3: count stays 3 and order is preserved; reset asserted mid-run -> all outputs reach reset values one cycle later, and req restarts at PC 0.
